// File: rtl/anim_sequencer.sv
// anim_sequencer: button-driven sequencing for the seven-segment animation
// datapath. Owns the animation index, the frame-period speed setting, the
// frame tick/counter and the blank/run/pause sequencing, so the downstream
// segment decoder and animation lookup can stay purely combinational.
//
// Optional feature: define ANIM_AUTOPLAY_EN to advance to the next
// animation automatically after every fourth frame wrap while running.

`timescale 1ns/1ps

module anim_sequencer #(
   parameter int NUM_ANIM     = 12,
   parameter int STEP_CYCLES  = 1000000,
   parameter int DEF_STEP     = 10,
   parameter int MIN_STEP     = 1,
   parameter int MAX_STEP     = 19,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_next_i,
   input  logic       btn_prev_i,
   input  logic       btn_faster_i,
   input  logic       btn_slower_i,
   input  logic       btn_pause_i,
   input  logic [4:0] frame_limit_i,
   output logic [3:0] anim_idx_o,
   output logic [4:0] frame_o,
   output logic       frame_tick_o,
   output logic [4:0] speed_step_o,
   output logic       blank_o,
   output logic       paused_o
);

   // Counter widths are derived from the cycle counts so that the
   // terminal values always fit; a one-cycle count still gets one bit.
   localparam int SubW = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;
   localparam int BlkW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

   localparam logic [SubW-1:0] SubLast  = SubW'(STEP_CYCLES - 1);
   localparam logic [BlkW-1:0] BlkLast  = BlkW'(BLANK_CYCLES - 1);
   localparam logic [3:0]      AnimLast = 4'(NUM_ANIM - 1);
   localparam logic [4:0]      DefStep  = 5'(DEF_STEP);
   localparam logic [4:0]      MinStep  = 5'(MIN_STEP);
   localparam logic [4:0]      MaxStep  = 5'(MAX_STEP);

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        anim_q, anim_d;
   logic [4:0]        frame_q, frame_d;
   logic [4:0]        speed_q, speed_d;
   logic [4:0]        stp_q, stp_d;
   logic [SubW-1:0]   sub_q, sub_d;
   logic [BlkW-1:0]   bcnt_q, bcnt_d;
   logic              tick_q, tick_d;

   logic              running;
   logic              termCount;
   logic              frameWrap;
   logic              manualChg;
   logic              autoNext;
   logic              animChange;

   // Decode the shared event conditions: running state, end of a frame
   // period, frame wrap, and whether the animation changes this cycle.
   always_comb begin
      running    = (state_q == ST_RUN);
      termCount  = (sub_q == SubLast) && (stp_q >= (speed_q - 5'd1));
      frameWrap  = running && termCount && (frame_q >= frame_limit_i);
      manualChg  = btn_next_i ^ btn_prev_i;
      animChange = manualChg || autoNext;
   end

`ifdef ANIM_AUTOPLAY_EN
   logic [1:0] wrap_q, wrap_d;

   // Count frame wraps; the fourth one requests an automatic next
   // animation, and any animation change restarts the count.
   always_comb begin
      autoNext = frameWrap && (wrap_q == 2'd3);
      wrap_d   = wrap_q;
      if (animChange) begin
         wrap_d = 2'd0;
      end else if (frameWrap) begin
         wrap_d = wrap_q + 2'd1;
      end
   end

   // Wrap counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrap_q <= 2'd0;
      end else begin
         wrap_q <= wrap_d;
      end
   end
`else
   // Without autoplay the animation only changes on button pulses.
   always_comb begin
      autoNext = 1'b0;
   end
`endif

   // State sequencing: blank interval, then run, with pause toggling;
   // an animation change always returns to the blank interval.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_BLANK: begin
            if (bcnt_q == BlkLast) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (btn_pause_i) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (btn_pause_i) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BLANK;
         end
      endcase
      if (animChange) begin
         state_d = ST_BLANK;
      end
   end

   // Blank interval counter; restarts on every animation change.
   always_comb begin
      bcnt_d = bcnt_q;
      if (animChange) begin
         bcnt_d = '0;
      end else if (state_q == ST_BLANK) begin
         if (bcnt_q == BlkLast) begin
            bcnt_d = '0;
         end else begin
            bcnt_d = bcnt_q + BlkW'(1);
         end
      end
   end

   // Frame period counters: sub counts clock cycles within a speed step,
   // stp counts whole steps; both hold outside RUN and clear on a tick.
   always_comb begin
      sub_d = sub_q;
      stp_d = stp_q;
      if (animChange) begin
         sub_d = '0;
         stp_d = 5'd0;
      end else if (running) begin
         if (termCount) begin
            sub_d = '0;
            stp_d = 5'd0;
         end else if (sub_q == SubLast) begin
            sub_d = '0;
            stp_d = stp_q + 5'd1;
         end else begin
            sub_d = sub_q + SubW'(1);
         end
      end
   end

   // Frame tick and frame index; a manual change drops the tick while the
   // automatic advance keeps the wrap tick that caused it.
   always_comb begin
      tick_d  = running && termCount && !manualChg;
      frame_d = frame_q;
      if (animChange) begin
         frame_d = 5'd0;
      end else if (running && termCount) begin
         if (frame_q >= frame_limit_i) begin
            frame_d = 5'd0;
         end else begin
            frame_d = frame_q + 5'd1;
         end
      end
   end

   // Animation index with wrap-around; a manual request beats autoplay.
   always_comb begin
      anim_d = anim_q;
      if (manualChg) begin
         if (btn_next_i) begin
            anim_d = (anim_q == AnimLast) ? 4'd0 : anim_q + 4'd1;
         end else begin
            anim_d = (anim_q == 4'd0) ? AnimLast : anim_q - 4'd1;
         end
      end else if (autoNext) begin
         anim_d = (anim_q == AnimLast) ? 4'd0 : anim_q + 4'd1;
      end
   end

   // Speed setting with saturation; opposing buttons cancel out.
   always_comb begin
      speed_d = speed_q;
      if (btn_faster_i && !btn_slower_i) begin
         speed_d = (speed_q > MinStep) ? speed_q - 5'd1 : MinStep;
      end else if (btn_slower_i && !btn_faster_i) begin
         speed_d = (speed_q < MaxStep) ? speed_q + 5'd1 : MaxStep;
      end
   end

   // All sequencing registers, synchronously reset into the blank state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BLANK;
         anim_q  <= 4'd0;
         frame_q <= 5'd0;
         speed_q <= DefStep;
         stp_q   <= 5'd0;
         sub_q   <= '0;
         bcnt_q  <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         anim_q  <= anim_d;
         frame_q <= frame_d;
         speed_q <= speed_d;
         stp_q   <= stp_d;
         sub_q   <= sub_d;
         bcnt_q  <= bcnt_d;
         tick_q  <= tick_d;
      end
   end

   // Outputs come straight from registers so they are glitch-free.
   always_comb begin
      anim_idx_o   = anim_q;
      frame_o      = frame_q;
      frame_tick_o = tick_q;
      speed_step_o = speed_q;
      blank_o      = (state_q == ST_BLANK);
      paused_o     = (state_q == ST_PAUSE);
   end

endmodule

// File: tb/tb_anim_sequencer.sv
// Testbench for anim_sequencer: directed walk through the main use cases
// followed by random button traffic, every cycle compared against a
// behavioural model that tracks elapsed cycles and remaining blank time.

`timescale 1ns/1ps

module tb_anim_sequencer;

   localparam int NumAnim     = 12;
   localparam int StepCycles  = 4;
   localparam int BlankCycles = 3;
   localparam int DefStep     = 2;
   localparam int MinStep     = 1;
   localparam int MaxStep     = 19;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btnNext = 1'b0;
   logic       btnPrev = 1'b0;
   logic       btnFaster = 1'b0;
   logic       btnSlower = 1'b0;
   logic       btnPause = 1'b0;
   logic [4:0] frameLimit = 5'd0;
   logic [3:0] animIdx;
   logic [4:0] frame;
   logic       frameTick;
   logic [4:0] speedStep;
   logic       blank;
   logic       paused;

   int testCount = 0;
   int failCount = 0;
   int cycle = 0;
   int curLimit = 0;

   // Reference model state
   int mAnim, mFrame, mSpeed, mElapsed, mBlankLeft, mWraps;
   bit mPaused, mTick;

   anim_sequencer #(
      .NUM_ANIM(NumAnim), .STEP_CYCLES(StepCycles), .DEF_STEP(DefStep),
      .MIN_STEP(MinStep), .MAX_STEP(MaxStep), .BLANK_CYCLES(BlankCycles)
   ) dut (
      .clk(clk), .reset(reset),
      .btn_next_i(btnNext), .btn_prev_i(btnPrev),
      .btn_faster_i(btnFaster), .btn_slower_i(btnSlower),
      .btn_pause_i(btnPause), .frame_limit_i(frameLimit),
      .anim_idx_o(animIdx), .frame_o(frame), .frame_tick_o(frameTick),
      .speed_step_o(speedStep), .blank_o(blank), .paused_o(paused)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic modelReset();
      mAnim = 0; mFrame = 0; mSpeed = DefStep; mElapsed = 0;
      mBlankLeft = BlankCycles; mWraps = 0; mPaused = 0; mTick = 0;
   endtask

   // One clock edge of the model: mElapsed is the number of running cycles
   // since the last tick, a period ends on the last cycle of a step once at
   // least speed-1 whole steps have already elapsed.
   task automatic modelStep(input bit n, input bit p, input bit f, input bit s,
                            input bit pa, input int lim);
      bit wasBlank;
      bit manual;
      bit autoAdv;
      wasBlank = (mBlankLeft > 0);
      manual   = n ^ p;
      autoAdv  = 0;
      mTick    = 0;
      if (!wasBlank && !mPaused) begin
         if ((mElapsed % StepCycles) == StepCycles - 1 &&
             (mElapsed / StepCycles) >= mSpeed - 1) begin
            mTick = 1;
            mElapsed = 0;
            if (mFrame >= lim) begin
               mFrame = 0;
               mWraps++;
            end else begin
               mFrame++;
            end
         end else begin
            mElapsed++;
         end
      end
`ifdef ANIM_AUTOPLAY_EN
      if (mWraps == 4) autoAdv = 1;
`endif
      if (wasBlank) mBlankLeft--;
      else if (pa) mPaused = !mPaused;
      if (manual || autoAdv) begin
         if (manual) begin
            mTick = 0;
            mAnim = n ? (mAnim + 1) % NumAnim : (mAnim + NumAnim - 1) % NumAnim;
         end else begin
            mAnim = (mAnim + 1) % NumAnim;
         end
         mFrame = 0; mElapsed = 0; mBlankLeft = BlankCycles;
         mPaused = 0; mWraps = 0;
      end
      if (f && !s) mSpeed = (mSpeed > MinStep) ? mSpeed - 1 : MinStep;
      if (s && !f) mSpeed = (mSpeed < MaxStep) ? mSpeed + 1 : MaxStep;
   endtask

   task automatic checkValue(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
      testCount++;
      assert (got === exp) else begin
         failCount++;
         $error("[TB] FAIL %s cycle %0d: observed %0d expected %0d",
                tag, cycle, got, exp);
      end
   endtask

   task automatic checkOutput();
      checkValue("anim_idx",   {28'd0, animIdx},   mAnim);
      checkValue("frame",      {27'd0, frame},     mFrame);
      checkValue("frame_tick", {31'd0, frameTick}, {31'd0, mTick});
      checkValue("speed_step", {27'd0, speedStep}, mSpeed);
      checkValue("blank",      {31'd0, blank},     (mBlankLeft > 0) ? 1 : 0);
      checkValue("paused",     {31'd0, paused},    {31'd0, mPaused});
   endtask

   // Drive one cycle of button pulses, advance the model, then compare
   task automatic applyStimulus(input bit n, input bit p, input bit f,
                                input bit s, input bit pa);
      btnNext = n; btnPrev = p; btnFaster = f; btnSlower = s; btnPause = pa;
      frameLimit = 5'(curLimit);
      @(posedge clk);
      modelStep(n, p, f, s, pa, curLimit);
      cycle++;
      #1;
      btnNext = 0; btnPrev = 0; btnFaster = 0; btnSlower = 0; btnPause = 0;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset and check the documented reset values
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      modelReset();
      reset = 1'b0;
      checkValue("reset anim_idx", {28'd0, animIdx}, 0);
      checkValue("reset speed", {27'd0, speedStep}, DefStep);
      checkValue("reset blank", {31'd0, blank}, 1);
      checkOutput();

      // Blank interval, then ticks with frame sequence 1,2,0
      curLimit = 2;
      idle(40);

      // Previous from 0 wraps to the last animation, next returns
      applyStimulus(0, 1, 0, 0, 0);
      checkValue("prev wrap", {28'd0, animIdx}, NumAnim - 1);
      idle(5);
      applyStimulus(1, 0, 0, 0, 0);
      checkValue("next wrap", {28'd0, animIdx}, 0);
      applyStimulus(1, 1, 0, 0, 0);
      checkValue("next+prev", {28'd0, animIdx}, 0);
      idle(10);

      // Speed saturation in both directions
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         idle(5);
      end
      checkValue("faster sat", {27'd0, speedStep}, MinStep);
      idle(12);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 0, 0, 1, 0);
         idle(1);
      end
      checkValue("slower sat", {27'd0, speedStep}, MaxStep);
      idle(160);

      // Pause mid-period, hold, then resume
      idle(30);
      applyStimulus(0, 0, 0, 0, 1);
      checkValue("pause on", {31'd0, paused}, 1);
      idle(50);
      applyStimulus(0, 0, 0, 0, 1);
      checkValue("pause off", {31'd0, paused}, 0);
      idle(100);

      // Animation change wins over pause, pause ignored in blank
      applyStimulus(0, 0, 0, 0, 1);
      idle(3);
      applyStimulus(1, 0, 0, 0, 1);
      checkValue("chg over pause", {31'd0, paused}, 0);
      checkValue("chg blank", {31'd0, blank}, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkValue("pause in blank", {31'd0, paused}, 0);
      idle(5);

      // Short frames for the wrap counter, with a manual change mid-way
      curLimit = 1;
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 0, 0);
      idle(60);
      idle(14);
      applyStimulus(1, 0, 0, 0, 0);
      idle(60);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0)
            curLimit = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 6));
         applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 63) == 0,
                       $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 31) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
